mem_port_arbiter: RTL

- Shares the single backing data-memory port between two cache-miss requesters: the instruction-side refill (read-only) and the data-side refill/write-back (read or write, byte-selected).
- Sits between the two cache controllers and the memory model.
- Serialises transactions: one outstanding at a time, round-robin under contention.
- A watchdog flags memories that never answer.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_port_arbiter_rr_arb2.sv | 37 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Pure declarations: no latency, no backpressure.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // byte address -> 32-bit word address
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin grant: combinational winner, registered last-grant pointer.
// Grant valid in the same cycle as the requests; pointer advances only on update.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic update,
  output logic grant,
  output logic any_req
);

  logic last_grant;

  always_comb begin
    grant = GRANT_I;
    if (i_req && d_req) begin
      grant = ~last_grant;
    end else if (d_req) begin
      grant = GRANT_D;
    end
  end

  assign any_req = i_req | d_req;

  // reset to D so the first contention goes to the instruction side
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= GRANT_D;
    end else if (update) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-side and D-side refills onto one memory port; 3 + N cycles request-to-ready.
// One transaction in flight; requesters hold req/operands until their ready pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_req,
  input  logic                d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_bsel,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                mem_ren,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_bsel,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_valid,
  output logic                busy,
  output logic                err
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  arb_state_t        state, state_nxt;
  logic              grant, any_req, arb_update;
  logic              grant_q;
  logic [WD_W-1:0]   wdog;
  logic [DATA_W-1:0] resp_q;
  logic              mem_done, wd_expire;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .d_req   (d_req),
    .update  (arb_update),
    .grant   (grant),
    .any_req (any_req)
  );

  assign arb_update = (state == IDLE) && any_req;
  assign mem_done   = (state == WAIT) && mem_valid;
  // a completion in the same cycle as expiry takes priority over the abort
  assign wd_expire  = (state == WAIT) && !mem_valid && (wdog == WD_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mem_done || wd_expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_q   <= GRANT_D;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_bsel  <= '0;
      wdog      <= '0;
      resp_q    <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_ren <= 1'b0;
      mem_wen <= 1'b0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;

      // operands captured once at grant and held until the next grant
      if (arb_update) begin
        grant_q <= grant;
        if (grant == GRANT_D) begin
          mem_addr  <= d_addr >> WORD_SHIFT;
          mem_wdata <= d_wdata;
          mem_bsel  <= d_bsel;
        end else begin
          mem_addr  <= i_addr >> WORD_SHIFT;
          mem_wdata <= '0;
          mem_bsel  <= '1;
        end
        mem_ren <= (grant == GRANT_I) || !d_wen;
        mem_wen <= (grant == GRANT_D) && d_wen;
      end

      if (state == ISSUE) begin
        wdog <= '0;
      end else if ((state == WAIT) && (wdog != WD_MAX)) begin
        wdog <= wdog + WD_W'(1);
      end

      if (mem_done || wd_expire) begin
        resp_q  <= mem_done ? mem_rdata : '0;
        i_ready <= (grant_q == GRANT_I);
        d_ready <= (grant_q == GRANT_D);
        err     <= wd_expire;
      end
    end
  end

  assign i_rdata = resp_q;
  assign d_rdata = resp_q;
  assign busy    = (state != IDLE);

endmodule
